// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus bundle: memory port plus controller handshake.
// The master modport belongs to fetch_sequencer; slave is the memory/controller side.
interface fetch_sequencer_if #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 4
);
    logic [DATA_W-1:0]   bus_in;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_oe_n;
    logic [OPCODE_W-1:0] op_code;
    logic [ADDR_W-1:0]   operand;
    logic                instr_valid;
    logic                exec_mem_rd;
    logic                exec_done;
    logic                jump_en;
    logic [ADDR_W-1:0]   jump_addr;
    logic                halt;
    logic                halted;
    logic [ADDR_W-1:0]   pc;

    modport master (
        input  bus_in, exec_mem_rd, exec_done, jump_en, jump_addr, halt,
        output mem_addr, mem_oe_n, op_code, operand, instr_valid, halted, pc
    );

    modport slave (
        output bus_in, exec_mem_rd, exec_done, jump_en, jump_addr, halt,
        input  mem_addr, mem_oe_n, op_code, operand, instr_valid, halted, pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: ADDR -> READ -> EXEC loop with a terminal HALT.
// Optional macro FETCH_WRAP_HALT_EN halts after the instruction whose fetch wrapped PC to 0.
module fetch_sequencer #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_ADDR = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_mar;
    logic [ADDR_W-1:0] w_mar_next;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] w_ir_next;
    logic [ADDR_W-1:0] w_operand;
    logic              w_halt_req;
    logic [ADDR_W-1:0] w_mem_addr;
    logic              w_mem_oe_n;
    logic              w_instr_valid;
    logic              w_halted;

    assign w_operand = r_ir[ADDR_W-1:0];

`ifdef FETCH_WRAP_HALT_EN
    logic r_wrap;
    logic w_wrap_next;

    // The wrapped instruction still executes; halting happens at its exec_done.
    assign w_halt_req = bus.halt | r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    always_comb begin
        w_wrap_next = r_wrap;
        if (r_state == ST_READ) begin
            w_wrap_next = &r_pc;
        end else if (r_state == ST_EXEC && bus.exec_done && !w_halt_req && bus.jump_en) begin
            w_wrap_next = 1'b0;
        end
    end
`else
    assign w_halt_req = bus.halt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ADDR;
            r_pc    <= '0;
            r_mar   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_mar   <= w_mar_next;
            r_ir    <= w_ir_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_mar_next    = r_mar;
        w_ir_next     = r_ir;
        w_mem_addr    = r_mar;
        w_mem_oe_n    = 1'b1;
        w_instr_valid = 1'b0;
        w_halted      = 1'b0;
        case (r_state)
            ST_ADDR: begin
                w_mar_next   = r_pc;
                w_state_next = ST_READ;
            end
            ST_READ: begin
                // Memory is combinational: bus_in is already valid for this address.
                w_mem_oe_n   = 1'b0;
                w_ir_next    = bus.bus_in;
                w_pc_next    = r_pc + ADDR_W'(1);
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                w_instr_valid = 1'b1;
                w_mem_addr    = w_operand;
                w_mem_oe_n    = ~bus.exec_mem_rd;
                if (bus.exec_done) begin
                    if (w_halt_req) begin
                        w_state_next = ST_HALT;
                    end else begin
                        if (bus.jump_en) begin
                            w_pc_next = bus.jump_addr;
                        end
                        w_state_next = ST_ADDR;
                    end
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_state_next = ST_ADDR;
            end
        endcase
    end

    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_oe_n    = w_mem_oe_n;
    assign bus.instr_valid = w_instr_valid;
    assign bus.halted      = w_halted;
    assign bus.op_code     = r_ir[DATA_W-1 -: OPCODE_W];
    assign bus.operand     = w_operand;
    assign bus.pc          = r_pc;

endmodule
